// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared types for the cache sequencing FSM and its checker.
package cache_controller_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } cache_state_e;

    function automatic int burst_words(input int line_size);
        return line_size / 4;
    endfunction

endpackage

// File: rtl/cache_controller_sva.sv
// cache_controller_sva: protocol and burst-length checker bound into every cache_controller.
module cache_controller_sva
    import cache_controller_pkg::*;
#(
    parameter bit READ_ONLY = 1'b0,
    parameter int LINE_SIZE = 32
) (
    input logic              clk,
    input logic              reset_n,
    input logic              req_valid,
    input memory_operation_e req_operation,
    input logic              req_fulfilled,
    input logic              hmem_req_valid,
    input memory_operation_e hmem_req_operation,
    input logic              hmem_req_fulfilled,
    input logic              valid_block_match,
    input logic              counter_done,
    input cache_state_e      state,
    input logic              replay
);
    localparam int WORDS = burst_words(LINE_SIZE);

    int beats;
    logic in_burst;

    assign in_burst = (state == WRITEBACK) || (state == FILL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            beats <= 0;
        else if (in_burst && hmem_req_fulfilled)
            beats <= counter_done ? 0 : beats + 1;
    end

    a_burst_len: assert property (@(posedge clk) disable iff (!reset_n)
        in_burst && hmem_req_fulfilled |-> (counter_done ? beats == WORDS - 1 : beats < WORDS - 1));

    a_ro_write: assert property (@(posedge clk) disable iff (!reset_n)
        req_valid |-> !(READ_ONLY && req_operation == WRITE));

    a_replay_hit: assert property (@(posedge clk) disable iff (!reset_n)
        state == LOOKUP && replay |-> valid_block_match);

    a_req_hold: assert property (@(posedge clk) disable iff (!reset_n)
        state != IDLE && !req_fulfilled |-> req_valid);

    a_hmem_hold: assert property (@(posedge clk) disable iff (!reset_n)
        hmem_req_valid && !hmem_req_fulfilled |=> hmem_req_valid && $stable(hmem_req_operation));

endmodule

bind cache_controller cache_controller_sva #(
    .READ_ONLY(READ_ONLY),
    .LINE_SIZE(LINE_SIZE)
) u_sva (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_operation(req_operation),
    .req_fulfilled(req_fulfilled),
    .hmem_req_valid(hmem_req_valid),
    .hmem_req_operation(hmem_req_operation),
    .hmem_req_fulfilled(hmem_req_fulfilled),
    .valid_block_match(valid_block_match),
    .counter_done(counter_done),
    .state(state),
    .replay(replay)
);

// File: rtl/cache_controller.sv
// cache_controller: sequences lookup, dirty-victim writeback and line fill, then replays the lookup.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter bit READ_ONLY = 1'b0,
    parameter int LINE_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  memory_operation_e req_operation,
    output logic              req_fulfilled,
    output logic              hmem_req_valid,
    output memory_operation_e hmem_req_operation,
    input  logic              hmem_req_fulfilled,
    input  logic              valid_block_match,
    input  logic              valid_dirty_bit,
    input  logic              counter_done,
    output logic              miss_recovery_mode,
    output logic              set_hmem_block_address,
    output logic              use_victim_tag_for_hmem_block_address,
    output logic              reset_counter,
    output logic              decrement_counter,
    output logic              perform_write,
    output logic              process_lru_counters,
    output logic              clear_selected_valid_bit,
    output logic              finish_new_line_install,
    output logic              clear_selected_dirty_bit,
    output logic              set_selected_dirty_bit,
    output logic              count_hit,
    output logic              count_miss,
    output logic              count_read,
    output logic              count_write,
    output logic              count_writeback
);
    cache_state_e state, next_state;
    logic replay, next_replay;
    logic is_write, dirty_victim;

    // READ_ONLY folds every write/dirty path away at elaboration
    assign is_write     = !READ_ONLY && req_operation == WRITE;
    assign dirty_victim = !READ_ONLY && valid_dirty_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            replay <= 1'b0;
        end else begin
            state  <= next_state;
            replay <= next_replay;
        end
    end

    always_comb begin
        next_state  = state;
        next_replay = replay;
        case (state)
            IDLE:      next_state = req_valid ? LOOKUP : IDLE;
            LOOKUP: begin
                next_state  = valid_block_match ? IDLE : (dirty_victim ? WRITEBACK : FILL);
                next_replay = valid_block_match ? 1'b0 : replay;
            end
            WRITEBACK: next_state = (hmem_req_fulfilled && counter_done) ? FILL : WRITEBACK;
            FILL: begin
                next_state  = (hmem_req_fulfilled && counter_done) ? LOOKUP : FILL;
                next_replay = (hmem_req_fulfilled && counter_done) ? 1'b1 : replay;
            end
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        req_fulfilled                         = 1'b0;
        hmem_req_valid                        = 1'b0;
        hmem_req_operation                    = READ;
        miss_recovery_mode                    = 1'b0;
        set_hmem_block_address                = 1'b0;
        use_victim_tag_for_hmem_block_address = 1'b0;
        reset_counter                         = 1'b0;
        decrement_counter                     = 1'b0;
        perform_write                         = 1'b0;
        process_lru_counters                  = 1'b0;
        clear_selected_valid_bit              = 1'b0;
        finish_new_line_install               = 1'b0;
        clear_selected_dirty_bit              = 1'b0;
        set_selected_dirty_bit                = 1'b0;
        count_hit                             = 1'b0;
        count_miss                            = 1'b0;
        count_read                            = 1'b0;
        count_write                           = 1'b0;
        count_writeback                       = 1'b0;
        case (state)
            IDLE: begin
                count_read  = req_valid && req_operation == READ;
                count_write = req_valid && req_operation == WRITE;
            end
            LOOKUP: begin
                if (valid_block_match) begin
                    process_lru_counters   = 1'b1;
                    req_fulfilled          = 1'b1;
                    perform_write          = is_write;
                    set_selected_dirty_bit = is_write;
                    count_hit              = !replay;
                end else begin
                    count_miss                            = 1'b1;
                    set_hmem_block_address                = 1'b1;
                    reset_counter                         = 1'b1;
                    use_victim_tag_for_hmem_block_address = dirty_victim;
                    count_writeback                       = dirty_victim;
                    clear_selected_valid_bit              = !dirty_victim;
                end
            end
            WRITEBACK: begin
                miss_recovery_mode       = 1'b1;
                hmem_req_valid           = 1'b1;
                hmem_req_operation       = WRITE;
                decrement_counter        = hmem_req_fulfilled && !counter_done;
                clear_selected_dirty_bit = hmem_req_fulfilled && counter_done;
                clear_selected_valid_bit = hmem_req_fulfilled && counter_done;
                set_hmem_block_address   = hmem_req_fulfilled && counter_done;
                reset_counter            = hmem_req_fulfilled && counter_done;
            end
            FILL: begin
                miss_recovery_mode      = 1'b1;
                hmem_req_valid          = 1'b1;
                hmem_req_operation      = READ;
                perform_write           = hmem_req_fulfilled;
                decrement_counter       = hmem_req_fulfilled && !counter_done;
                finish_new_line_install = hmem_req_fulfilled && counter_done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed checks of hit, miss, writeback, stall, reset and read-only behaviour.
module tb_cache_controller;
    import cache_controller_pkg::*;

    localparam int F = 0, HV = 1, HO = 2, MRM = 3, SHA = 4, UV = 5, RC = 6, DC = 7, PW = 8, LRU = 9;
    localparam int CV = 10, FIN = 11, CD = 12, SD = 13, CH = 14, CM = 15, CR = 16, CW = 17, CWB = 18;
    localparam int NO = 19;
    localparam int WORDS = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic req_valid, hmem_req_fulfilled, valid_block_match, valid_dirty_bit, counter_done;
    memory_operation_e req_operation;
    logic ro_req_valid, ro_hmem_req_fulfilled, ro_match, ro_dirty, ro_counter_done;
    memory_operation_e ro_op;
    logic [NO-1:0] o, ro;

    int cnt [NO];
    int rcnt [NO];
    int fill_cyc, wr_cyc, bad_dec, uv_bad;
    int n_checks = 0, n_err = 0;
    int stall = 0;
    int lat;
    logic [NO-1:0] fo;

    always #5 clk = ~clk;

    cache_controller #(.READ_ONLY(1'b0), .LINE_SIZE(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_operation(req_operation), .req_fulfilled(o[F]),
        .hmem_req_valid(o[HV]), .hmem_req_operation(o[HO]), .hmem_req_fulfilled(hmem_req_fulfilled),
        .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit), .counter_done(counter_done),
        .miss_recovery_mode(o[MRM]), .set_hmem_block_address(o[SHA]),
        .use_victim_tag_for_hmem_block_address(o[UV]), .reset_counter(o[RC]),
        .decrement_counter(o[DC]), .perform_write(o[PW]), .process_lru_counters(o[LRU]),
        .clear_selected_valid_bit(o[CV]), .finish_new_line_install(o[FIN]),
        .clear_selected_dirty_bit(o[CD]), .set_selected_dirty_bit(o[SD]),
        .count_hit(o[CH]), .count_miss(o[CM]), .count_read(o[CR]), .count_write(o[CW]),
        .count_writeback(o[CWB])
    );

    cache_controller #(.READ_ONLY(1'b1), .LINE_SIZE(32)) dut_ro (
        .clk(clk), .reset_n(reset_n),
        .req_valid(ro_req_valid), .req_operation(ro_op), .req_fulfilled(ro[F]),
        .hmem_req_valid(ro[HV]), .hmem_req_operation(ro[HO]), .hmem_req_fulfilled(ro_hmem_req_fulfilled),
        .valid_block_match(ro_match), .valid_dirty_bit(ro_dirty), .counter_done(ro_counter_done),
        .miss_recovery_mode(ro[MRM]), .set_hmem_block_address(ro[SHA]),
        .use_victim_tag_for_hmem_block_address(ro[UV]), .reset_counter(ro[RC]),
        .decrement_counter(ro[DC]), .perform_write(ro[PW]), .process_lru_counters(ro[LRU]),
        .clear_selected_valid_bit(ro[CV]), .finish_new_line_install(ro[FIN]),
        .clear_selected_dirty_bit(ro[CD]), .set_selected_dirty_bit(ro[SD]),
        .count_hit(ro[CH]), .count_miss(ro[CM]), .count_read(ro[CR]), .count_write(ro[CW]),
        .count_writeback(ro[CWB])
    );

    // pulse/cycle tallies, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < NO; i++) begin
            cnt[i]  += int'(o[i] === 1'b1);
            rcnt[i] += int'(ro[i] === 1'b1);
        end
        fill_cyc += int'(o[HV] === 1'b1 && o[HO] === 1'b0);
        wr_cyc   += int'(o[HV] === 1'b1 && o[HO] === 1'b1);
        bad_dec  += int'(o[DC] === 1'b1 && hmem_req_fulfilled !== 1'b1);
        uv_bad   += int'(o[UV] === 1'b1 && o[HV] === 1'b1);
    end

    // higher-memory responder plus datapath word-counter model
    initial begin
        logic p_rc, p_dc, r_rc, r_dc;
        int c_m, c_r, w;
        p_rc = 0; p_dc = 0; r_rc = 0; r_dc = 0;
        c_m = WORDS - 1; c_r = WORDS - 1; w = 0;
        hmem_req_fulfilled = 0; ro_hmem_req_fulfilled = 0;
        counter_done = 0; ro_counter_done = 0;
        forever begin
            @(negedge clk);
            p_rc = o[RC]; p_dc = o[DC]; r_rc = ro[RC]; r_dc = ro[DC];
            @(posedge clk);
            #1;
            if (p_rc === 1'b1) c_m = WORDS - 1; else if (p_dc === 1'b1) c_m--;
            if (r_rc === 1'b1) c_r = WORDS - 1; else if (r_dc === 1'b1) c_r--;
            counter_done = (c_m == 0);
            ro_counter_done = (c_r == 0);
            if (o[HV] === 1'b1) begin
                if (w >= stall) begin hmem_req_fulfilled = 1; w = 0; end
                else begin hmem_req_fulfilled = 0; w++; end
            end else begin
                hmem_req_fulfilled = 0; w = 0;
            end
            ro_hmem_req_fulfilled = (ro[HV] === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < NO; i++) begin cnt[i] = 0; rcnt[i] = 0; end
        fill_cyc = 0; wr_cyc = 0; bad_dec = 0; uv_bad = 0;
    endtask

    // one full transaction; lat counts cycles from req_valid (=1) to req_fulfilled
    task automatic run(input bit sel, input memory_operation_e op, input logic match, input logic dirty,
                       output int l, output logic [NO-1:0] f);
        bit seen;
        step();
        clr();
        if (sel) begin ro_req_valid = 1; ro_match = match; ro_dirty = dirty; end
        else begin req_valid = 1; req_operation = op; valid_block_match = match; valid_dirty_bit = dirty; end
        l = 1; f = '0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            l++;
            if (l == 3) begin valid_block_match = 1; valid_dirty_bit = 0; ro_match = 1; ro_dirty = 0; end
            #1;
            if ((sel ? ro[F] : o[F]) === 1'b1) begin seen = 1; f = sel ? ro : o; end
        end
        check("fulfil_seen", {31'd0, seen}, 32'd1);
        step();
        req_valid = 0; ro_req_valid = 0;
    endtask

    initial begin
        reset_n = 0; req_valid = 0; req_operation = READ; valid_block_match = 0; valid_dirty_bit = 0;
        ro_req_valid = 0; ro_op = READ; ro_match = 0; ro_dirty = 0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {13'd0, o}, 32'd0);
        check("rst_ro_outputs", {13'd0, ro}, 32'd0);
        reset_n = 1;
        step();
        check("idle_outputs", {13'd0, o}, 32'd0);

        run(0, READ, 1, 0, lat, fo);
        check("rd_hit_lat", lat, 2);
        check("rd_hit_count_read", cnt[CR], 1);
        check("rd_hit_count_hit", cnt[CH], 1);
        check("rd_hit_lru", cnt[LRU], 1);
        check("rd_hit_fulfilled", cnt[F], 1);
        check("rd_hit_hmem", cnt[HV], 0);
        check("rd_hit_pw", cnt[PW], 0);

        run(0, WRITE, 1, 0, lat, fo);
        check("wr_hit_lat", lat, 2);
        check("wr_hit_pw", fo[PW], 1);
        check("wr_hit_sd", fo[SD], 1);
        check("wr_hit_count_write", cnt[CW], 1);
        check("wr_hit_count_read", cnt[CR], 0);

        run(0, READ, 0, 0, lat, fo);
        check("miss_lat", lat, 11);
        check("miss_pw", cnt[PW], 8);
        check("miss_dec", cnt[DC], 7);
        check("miss_fin", cnt[FIN], 1);
        check("miss_count_miss", cnt[CM], 1);
        check("miss_count_hit", cnt[CH], 0);
        check("miss_fill_cyc", fill_cyc, 8);
        check("miss_clear_valid", cnt[CV], 1);
        check("miss_reset_counter", cnt[RC], 1);
        check("miss_wb", cnt[CWB], 0);

        run(0, READ, 1, 0, lat, fo);
        check("hit_after_replay_count_hit", cnt[CH], 1);

        run(0, WRITE, 0, 1, lat, fo);
        check("dirty_lat", lat, 19);
        check("dirty_wr_cyc", wr_cyc, 8);
        check("dirty_fill_cyc", fill_cyc, 8);
        check("dirty_uv", cnt[UV], 1);
        check("dirty_uv_in_burst", uv_bad, 0);
        check("dirty_count_wb", cnt[CWB], 1);
        check("dirty_clear_dirty", cnt[CD], 1);
        check("dirty_clear_valid", cnt[CV], 1);
        check("dirty_sha", cnt[SHA], 2);
        check("dirty_pw", cnt[PW], 9);
        check("dirty_dec", cnt[DC], 14);
        check("dirty_final_pw", fo[PW], 1);
        check("dirty_final_sd", fo[SD], 1);
        check("dirty_count_hit", cnt[CH], 0);

        stall = 5;
        run(0, READ, 0, 0, lat, fo);
        check("stall_lat", lat, 51);
        check("stall_fill_cyc", fill_cyc, 48);
        check("stall_dec", cnt[DC], 7);
        check("stall_early_dec", bad_dec, 0);
        check("stall_pw", cnt[PW], 8);
        stall = 0;

        step();
        clr();
        req_valid = 1; req_operation = READ; valid_block_match = 0; valid_dirty_bit = 0;
        repeat (4) step();
        #1;
        check("beat3_fill_state", {30'd0, o[HV], o[HO]}, 32'd2);
        check("beat3_prior_pw", cnt[PW], 2);
        #1;
        reset_n = 0; req_valid = 0;
        #1;
        check("async_reset_outputs", {13'd0, o}, 32'd0);
        step();
        reset_n = 1;
        #1;
        check("idle_after_reset", {13'd0, o}, 32'd0);
        run(0, READ, 0, 0, lat, fo);
        check("restart_lat", lat, 11);
        check("restart_reset_counter", cnt[RC], 1);
        check("restart_pw", cnt[PW], 8);
        check("restart_fin", cnt[FIN], 1);

        run(1, READ, 0, 1, lat, fo);
        check("ro_lat", lat, 11);
        check("ro_count_wb", rcnt[CWB], 0);
        check("ro_uv", rcnt[UV], 0);
        check("ro_clear_dirty", rcnt[CD], 0);
        check("ro_clear_valid", rcnt[CV], 1);
        check("ro_pw", rcnt[PW], 8);
        check("ro_dec", rcnt[DC], 7);
        check("ro_count_miss", rcnt[CM], 1);
        check("ro_count_read", rcnt[CR], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the cache datapath. It accepts one requester transaction at a time and decides hit or miss from the metadata status.
- On a miss it runs a dirty-victim writeback burst, then a line-fill burst, to higher memory. It then replays the lookup so the original access completes as a hit.
- It drives every control strobe of cache_internal_if plus the request/higher-memory handshakes. It instantiates alongside cache_datapath inside the cache top.

Parameters:
- READ_ONLY, 0, 1 removes all writeback/dirty paths; write requests are illegal (assertion).
- LINE_SIZE, 32, bytes per line; used only for burst-length assertions (LINE_SIZE/4 words).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  requester transaction pending; held with address/op stable until req_fulfilled
- req_operation  in  memory_operation_e  READ or WRITE
- req_fulfilled  out  1  one-cycle completion pulse; load data valid this cycle
- hmem_req_valid  out  1  higher-memory word request
- hmem_req_operation  out  memory_operation_e  READ (fill) / WRITE (writeback)
- hmem_req_fulfilled  in  1  higher memory accepted/returned current word
- valid_block_match  in  1  lookup hit (metadata)
- valid_dirty_bit  in  1  selected victim valid and dirty
- counter_done  in  1  word counter at last word
- miss_recovery_mode, set_hmem_block_address, use_victim_tag_for_hmem_block_address, reset_counter, decrement_counter, perform_write, process_lru_counters, clear_selected_valid_bit, finish_new_line_install, clear_selected_dirty_bit, set_selected_dirty_bit  out  1 each  datapath strobes
- count_hit, count_miss, count_read, count_write, count_writeback  out  1 each  perf pulses

Behaviour:
- Reset: state=IDLE, replay flag=0; all outputs combinational from state, so all are 0 in IDLE with req_valid=0. Assertion of reset_n mid-burst aborts immediately; the line is left invalid or dirty as metadata holds it.
- IDLE: on req_valid, pulse count_read (READ) or count_write (WRITE) and go to LOOKUP. Otherwise stay.
- LOOKUP, 1 cycle, metadata combinational:
  - Hit: process_lru_counters=1, req_fulfilled=1; go to IDLE and clear replay.
  - Hit on WRITE (READ_ONLY=0): additionally perform_write=1 and set_selected_dirty_bit=1.
  - count_hit only when replay=0. A minimum hit therefore takes 2 cycles from req_valid to req_fulfilled.
  - Miss: count_miss=1, set_hmem_block_address=1, reset_counter=1.
  - Miss with valid_dirty_bit and READ_ONLY=0: use_victim_tag_for_hmem_block_address=1, count_writeback=1; go to WRITEBACK.
  - Miss otherwise: clear_selected_valid_bit=1; go to FILL.
- WRITEBACK:
  - miss_recovery_mode=1, hmem_req_valid=1, hmem_req_operation=WRITE.
  - On hmem_req_fulfilled with !counter_done: decrement_counter=1.
  - On hmem_req_fulfilled with counter_done: clear_selected_dirty_bit=1, clear_selected_valid_bit=1, set_hmem_block_address=1 (use_victim=0), reset_counter=1; go to FILL.
- FILL:
  - miss_recovery_mode=1, hmem_req_valid=1, hmem_req_operation=READ.
  - On hmem_req_fulfilled: perform_write=1.
  - If also !counter_done: decrement_counter=1.
  - If also counter_done: finish_new_line_install=1, set replay=1; go to LOOKUP.
- hmem_req_valid stays high, with operation stable, until hmem_req_fulfilled; no stall limit.
- Replay LOOKUP on a miss (metadata fault) → assertion failure.
- Word bursts are exactly LINE_SIZE/4 fulfilled beats. The counter counts down and done=last word; an assertion checks the beat count per burst.
- req_valid deasserting before req_fulfilled is a protocol violation (assertion). Behaviour is undefined.
- No two of perform_write, clear_selected_valid_bit, finish_new_line_install are required simultaneously except as listed.

Decomposition:
- torrence_types gains cache_state_e {IDLE, LOOKUP, WRITEBACK, FILL}; memory_operation_e is reused.
- Single module: state register, replay flag, and a combinational output decoder in one always_comb. No sub-module is warranted.
- Assertions sit in a bound checker, cache_controller_sva.

Test Plan:
- Read hit (valid_block_match=1) → req_fulfilled 2nd cycle after req_valid; count_read, count_hit, process_lru_counters each 1 pulse; no hmem_req_valid.
- Clean read miss, LINE_SIZE=32, hmem fulfils every cycle → 8 FILL beats with perform_write each, 7 decrement_counter, then finish_new_line_install. Replay hit fulfils; count_miss=1, count_hit=0.
- Dirty write miss → 8 WRITE beats with use_victim asserted only at LOOKUP, count_writeback=1, then 8 READ beats. Final hit has perform_write and set_selected_dirty_bit.
- hmem stalls 5 cycles per beat → hmem_req_valid held stable, no decrement until fulfilled, total FILL = 48 cycles.
- reset_n low on FILL beat 3 → all outputs 0 asynchronously; IDLE after release; a new read miss restarts with reset_counter.
- READ_ONLY=1, dirty status high on miss → goes straight to FILL, count_writeback never pulses.
